// File: rtl/sdram_model_ctrl.sv
// sdram_model_ctrl: fixed-latency single-byte SDRAM responder with a behavioural backing array
module sdram_model_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_sdram,
  input  logic                  wr_rd_sdram,
  input  logic                  mstrb_sdram,
  input  logic [DATA_WIDTH-1:0] din_sdram,
  output logic [DATA_WIDTH-1:0] DOut_sdram,
  output logic                  sdram_busy,
  output logic                  sdram_done,
  output logic                  overrun_err,
  output logic [15:0]           access_count
);
  localparam logic       IDLE     = 1'b0;
  localparam logic       ACCESS   = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  logic                      r_state;
  logic [3:0]                r_cnt;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic                      r_wr;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [DATA_WIDTH-1:0]     r_mem [2**MEM_ADDR_WIDTH];
  logic                      w_complete;
  logic                      w_accept;
  logic                      w_overrun;
  logic                      w_unused;
  // Upper address bits alias onto the array and are intentionally dropped.
  assign w_unused   = ^Address_sdram;
  assign w_complete = r_state == ACCESS && r_cnt == 4'd0;
  assign w_accept   = mstrb_sdram && (r_state == IDLE || w_complete);
  assign w_overrun  = mstrb_sdram && r_state == ACCESS && r_cnt != 4'd0;
  assign sdram_busy = r_state;
  // Request FSM, latency counter, captured request and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_data       <= '0;
      DOut_sdram   <= '0;
      sdram_done   <= 1'b0;
      overrun_err  <= 1'b0;
      access_count <= 16'd0;
    end else begin
      r_state      <= w_accept ? ACCESS : (w_complete ? IDLE : r_state);
      r_cnt        <= w_accept ? CNT_LOAD : (r_cnt != 4'd0 ? r_cnt - 4'd1 : 4'd0);
      r_addr       <= w_accept ? Address_sdram[MEM_ADDR_WIDTH-1:0] : r_addr;
      r_wr         <= w_accept ? wr_rd_sdram : r_wr;
      r_data       <= w_accept ? din_sdram : r_data;
      DOut_sdram   <= (w_complete && !r_wr) ? r_mem[r_addr] : DOut_sdram;
      sdram_done   <= w_complete;
      overrun_err  <= overrun_err | w_overrun;
      access_count <= (w_complete && access_count != 16'hFFFF) ? access_count + 16'd1 : access_count;
    end
  end
  // Backing array: unaffected by reset, written only on a write's completion edge.
  always_ff @(posedge clk) begin
    if (w_complete && r_wr) r_mem[r_addr] <= r_data;
  end
endmodule

// File: tb/tb_sdram_model_ctrl.sv
// tb_sdram_model_ctrl: randomized self-checking bench against a behavioural memory/timing model
module tb_sdram_model_ctrl;
  localparam int L = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic        wr = 1'b0;
  logic        mstrb = 1'b0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        busy, done, ovr;
  logic [15:0] cnt;
  logic [15:0] b_addr = '0;
  logic        b_wr = 1'b0;
  logic        b_mstrb = 1'b0;
  logic [7:0]  b_din = '0;
  logic [7:0]  b_dout;
  logic        b_busy, b_done, b_ovr;
  logic [15:0] b_cnt;
  int          cyc = 0;
  int          dq_cyc[$];
  logic [7:0]  dq_dat[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model [logic [15:0]];
  logic [7:0]  mdout = 8'h00;
  int          exp_count = 0;

  sdram_model_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(16), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .Address_sdram(addr), .wr_rd_sdram(wr), .mstrb_sdram(mstrb),
    .din_sdram(din), .DOut_sdram(dout), .sdram_busy(busy), .sdram_done(done),
    .overrun_err(ovr), .access_count(cnt));

  sdram_model_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .Address_sdram(b_addr), .wr_rd_sdram(b_wr), .mstrb_sdram(b_mstrb),
    .din_sdram(b_din), .DOut_sdram(b_dout), .sdram_busy(b_busy), .sdram_done(b_done),
    .overrun_err(b_ovr), .access_count(b_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) begin
    dq_cyc.push_back(cyc);
    dq_dat.push_back(dout);
  end

  // Called at a negedge; returns at the negedge just before the completion edge so the
  // caller may strobe the next request onto that completion edge.
  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d, output int acc);
    addr = a; wr = w; din = d; mstrb = 1'b1; acc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    mstrb = 1'b0;
    repeat (L - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", ovr); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reset_count got=%0h exp=0", cnt); end
    rst = 1'b1;
    dq_cyc.delete(); dq_dat.delete();
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    checks++; if (dq_cyc.size() != 0) begin errors++; $display("FAIL idle_done_pulses got=%0d exp=0", dq_cyc.size()); end
  endtask

  task automatic test_write_read;
    int acc;
    int ec[$];
    logic [7:0] ed[$];
    dq_cyc.delete(); dq_dat.delete();
    drive(16'h1234, 1'b1, 8'hA5, acc);
    model[16'h1234] = 8'hA5; exp_count++;
    ec.push_back(acc + L); ed.push_back(mdout);
    @(negedge clk);
    checks++; if (cnt !== 16'(exp_count)) begin errors++; $display("FAIL wr_count got=%0d exp=%0d", cnt, exp_count); end
    drive(16'h1234, 1'b0, 8'h00, acc);
    mdout = model[16'h1234]; exp_count++;
    ec.push_back(acc + L); ed.push_back(mdout);
    repeat (2) @(negedge clk);
    checks++; if (cnt !== 16'(exp_count)) begin errors++; $display("FAIL rd_count got=%0d exp=%0d", cnt, exp_count); end
    checks++; if (dq_cyc.size() != ec.size()) begin errors++; $display("FAIL wr_rd_pulses got=%0d exp=%0d", dq_cyc.size(), ec.size()); end
    for (int i = 0; i < ec.size() && i < dq_cyc.size(); i++) begin
      checks++; if (dq_cyc[i] != ec[i]) begin errors++; $display("FAIL wr_rd_done_cycle[%0d] got=%0d exp=%0d", i, dq_cyc[i], ec[i]); end
      checks++; if (dq_dat[i] !== ed[i]) begin errors++; $display("FAIL wr_rd_data[%0d] got=%0h exp=%0h", i, dq_dat[i], ed[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    logic [7:0] ed[$];
    dq_cyc.delete(); dq_dat.delete();
    for (int i = 0; i < 32; i++) begin
      drive(16'h0400 + 16'(i), 1'b1, 8'(i), acc);
      model[16'h0400 + 16'(i)] = 8'(i); exp_count++;
      ed.push_back(mdout);
    end
    for (int i = 0; i < 32; i++) begin
      drive(16'h0400 + 16'(i), 1'b0, 8'h00, acc);
      mdout = model[16'h0400 + 16'(i)]; exp_count++;
      ed.push_back(mdout);
    end
    repeat (2) @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%0b exp=0", ovr); end
    checks++; if (cnt !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", cnt, exp_count); end
    checks++; if (dq_cyc.size() != 64) begin errors++; $display("FAIL b2b_pulses got=%0d exp=64", dq_cyc.size()); end
    for (int i = 0; i < 64 && i < dq_cyc.size(); i++) begin
      if (i > 0) begin
        checks++; if (dq_cyc[i] - dq_cyc[i-1] != L) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, dq_cyc[i] - dq_cyc[i-1], L); end
      end
      checks++; if (dq_dat[i] !== ed[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, dq_dat[i], ed[i]); end
    end
  endtask

  task automatic test_random;
    int acc;
    int ec[$];
    logic [7:0] ed[$];
    logic [15:0] a;
    logic w;
    logic [7:0] d;
    dq_cyc.delete(); dq_dat.delete();
    for (int i = 0; i < 40; i++) begin
      a = 16'h2000 + 16'($urandom_range(0, 15));
      w = !model.exists(a) || ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      drive(a, w, d, acc);
      if (w) model[a] = d;
      else mdout = model[a];
      exp_count++;
      ec.push_back(acc + L); ed.push_back(mdout);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rand_overrun got=%0b exp=0", ovr); end
    checks++; if (cnt !== 16'(exp_count)) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", cnt, exp_count); end
    checks++; if (dq_cyc.size() != ec.size()) begin errors++; $display("FAIL rand_pulses got=%0d exp=%0d", dq_cyc.size(), ec.size()); end
    for (int i = 0; i < ec.size() && i < dq_cyc.size(); i++) begin
      checks++; if (dq_cyc[i] != ec[i]) begin errors++; $display("FAIL rand_done_cycle[%0d] got=%0d exp=%0d", i, dq_cyc[i], ec[i]); end
      checks++; if (dq_dat[i] !== ed[i]) begin errors++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, dq_dat[i], ed[i]); end
    end
  endtask

  task automatic test_overrun;
    int acc;
    int acc2;
    dq_cyc.delete(); dq_dat.delete();
    addr = 16'h1234; wr = 1'b0; mstrb = 1'b1; acc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    mstrb = 1'b0;
    @(negedge clk);
    addr = 16'h1234; wr = 1'b1; din = 8'h5A; mstrb = 1'b1;
    @(negedge clk);
    mstrb = 1'b0;
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b exp=1", ovr); end
    repeat (6) @(negedge clk);
    mdout = model[16'h1234]; exp_count++;
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%0b exp=1", ovr); end
    checks++; if (dq_cyc.size() != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", dq_cyc.size()); end
    if (dq_cyc.size() > 0) begin
      checks++; if (dq_cyc[0] != acc + L) begin errors++; $display("FAIL ovr_done_cycle got=%0d exp=%0d", dq_cyc[0], acc + L); end
      checks++; if (dq_dat[0] !== mdout) begin errors++; $display("FAIL ovr_first_data got=%0h exp=%0h", dq_dat[0], mdout); end
    end
    drive(16'h1234, 1'b0, 8'h00, acc2);
    exp_count++;
    repeat (2) @(negedge clk);
    checks++; if (dout !== model[16'h1234]) begin errors++; $display("FAIL ovr_dropped_write got=%0h exp=%0h", dout, model[16'h1234]); end
    checks++; if (cnt !== 16'(exp_count)) begin errors++; $display("FAIL ovr_count got=%0d exp=%0d", cnt, exp_count); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_still_set got=%0b exp=1", ovr); end
  endtask

  task automatic test_reset_mid;
    int acc;
    drive(16'h0010, 1'b1, 8'h11, acc);
    model[16'h0010] = 8'h11;
    repeat (2) @(negedge clk);
    dq_cyc.delete(); dq_dat.delete();
    addr = 16'h0010; wr = 1'b1; din = 8'h3C; mstrb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mstrb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL rstmid_count got=%0h exp=0", cnt); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got=%0h exp=0", dout); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got=%0b exp=0", ovr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_count = 0; mdout = 8'h00;
    repeat (8) @(negedge clk);
    checks++; if (dq_cyc.size() != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dq_cyc.size()); end
    drive(16'h0010, 1'b0, 8'h00, acc);
    mdout = model[16'h0010]; exp_count++;
    repeat (2) @(negedge clk);
    checks++; if (dout !== mdout) begin errors++; $display("FAIL rstmid_preserved got=%0h exp=%0h", dout, mdout); end
    checks++; if (cnt !== 16'(exp_count)) begin errors++; $display("FAIL rstmid_recount got=%0d exp=%0d", cnt, exp_count); end
  endtask

  task automatic test_alias;
    b_addr = 16'h0105; b_wr = 1'b1; b_din = 8'h77; b_mstrb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_mstrb = 1'b0;
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL alias_busy got=%0b exp=1", b_busy); end
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL alias_wr_done got=%0b exp=1", b_done); end
    b_addr = 16'h0005; b_wr = 1'b0; b_mstrb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_mstrb = 1'b0;
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL alias_rd_done got=%0b exp=1", b_done); end
    checks++; if (b_dout !== 8'h77) begin errors++; $display("FAIL alias_data got=%0h exp=77", b_dout); end
    checks++; if (b_cnt !== 16'd2) begin errors++; $display("FAIL alias_count got=%0d exp=2", b_cnt); end
  endtask

  task automatic test_saturation;
    b_addr = 16'h0005; b_wr = 1'b0; b_mstrb = 1'b1;
    repeat (65533) @(negedge clk);
    checks++; if (b_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%0h exp=fffe", b_cnt); end
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL sat_busy got=%0b exp=1", b_busy); end
    repeat (2) @(negedge clk);
    checks++; if (b_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ffff", b_cnt); end
    b_mstrb = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (b_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%0h exp=ffff", b_cnt); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL sat_idle got=%0b exp=0", b_busy); end
    checks++; if (b_ovr !== 1'b0) begin errors++; $display("FAIL sat_overrun got=%0b exp=0", b_ovr); end
    checks++; if (b_dout !== 8'h77) begin errors++; $display("FAIL sat_data got=%0h exp=77", b_dout); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_random;
    test_overrun;
    test_reset_mid;
    test_alias;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_model_ctrl.md
Name: sdram_model_ctrl

Overview:
- Behavioural SDRAM-side responder that sits directly downstream of the cache controller's SDRAM interface.
- Accepts single-byte read/write requests qualified by mstrb_sdram.
- Models a fixed access latency and returns read data on DOut_sdram.
- Gives the cache block-fill and write-back paths a cycle-accurate backing store for simulation and FPGA bring-up.

Parameters:
ADDR_WIDTH, 16, width of Address_sdram
DATA_WIDTH, 8, data word width
MEM_ADDR_WIDTH, 16, index bits of the backing array; depth = 2**MEM_ADDR_WIDTH
LATENCY, 4, cycles from strobe-accept edge to completion edge; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
Address_sdram  input  ADDR_WIDTH  request address from cache controller
wr_rd_sdram  input  1  1 = write, 0 = read
mstrb_sdram  input  1  request strobe, sampled on rising edge
din_sdram  input  DATA_WIDTH  write data from cache SRAM
DOut_sdram  output  DATA_WIDTH  read data to cache fill mux
sdram_busy  output  1  high while a request is in progress
sdram_done  output  1  one-cycle pulse on completion of each request
overrun_err  output  1  sticky: strobe arrived while busy and not completing
access_count  output  16  number of completed requests, saturating

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, DOut_sdram=0, sdram_busy=0, sdram_done=0, overrun_err=0, access_count=0, latency counter=0.
- Backing array contents are NOT affected by reset. The bench initialises memory by writes.
- Reset asserted mid-access aborts the request: no array write, no done pulse.
- FSM has two states, IDLE and ACCESS.
- Accept (IDLE, mstrb_sdram=1 at an edge):
  - Capture Address_sdram[MEM_ADDR_WIDTH-1:0], wr_rd_sdram and din_sdram into request registers.
  - Load cnt=LATENCY-1; go to ACCESS; sdram_busy=1 from the next cycle.
- ACCESS with cnt>0: decrement cnt each edge. Inputs are ignored except for error detection.
- Completion edge (ACCESS, cnt==0):
  - Write: mem[addr_q] <= data_q.
  - Read: DOut_sdram <= mem[addr_q].
  - sdram_done=1 for exactly the following cycle.
  - access_count increments, saturating at 16'hFFFF.
- Back-to-back: if mstrb_sdram=1 on the completion edge, the new request is accepted on that same edge. State stays ACCESS, cnt reloads, busy stays 1, and no overrun is flagged.
- If mstrb_sdram=0 on the completion edge: go to IDLE, busy=0.
- Overrun: mstrb_sdram=1 at any ACCESS edge with cnt>0 sets overrun_err. That strobe is dropped and the flag is cleared only by reset.
- Latency: a request accepted at edge N completes at edge N+LATENCY. sdram_done is high and read data valid in the cycle after edge N+LATENCY.
- With LATENCY=1, accept and completion are consecutive edges.
- DOut_sdram holds the last read value until the next read completes; writes do not change it.
- Address wrap/aliasing: bits of Address_sdram above MEM_ADDR_WIDTH are discarded, with no error.
- Read-after-write to the same address in back-to-back requests returns the newly written value, because the write commits on the edge that accepts the read.
- Read data path is registered only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then released -> all outputs 0, busy=0, no done pulse for 20 cycles.
- Write then read (LATENCY=4):
  - Strobe write 0xA5 to 0x1234 at edge 0 -> done high in the cycle after edge 4, access_count=1.
  - Strobe read 0x1234 -> DOut_sdram=0xA5 with done, access_count=2.
- Back-to-back block: 32 writes 0x00..0x1F to 0x0400..0x041F, each strobe on its predecessor's completion edge, then 32 reads:
  - Required: overrun_err=0, 64 done pulses spaced exactly 4 cycles apart.
  - Read data equals 0x00..0x1F in order; access_count=64.
- Overrun: strobe at edge 0, second strobe at edge 2 -> overrun_err=1 and stays 1. Only one done pulse occurs (after edge 4), and the first request completes correctly.
- Reset mid-access: write 0x3C to 0x0010 accepted, rst pulsed low at edge 2:
  - Outputs return to 0 immediately and no done pulse occurs.
  - A later read of 0x0010 returns the previously written value, not 0x3C.
- Aliasing/saturation (MEM_ADDR_WIDTH=8):
  - Write 0x77 to 0x0105, read 0x0005 -> 0x77.
  - Force access_count to 0xFFFE via 2 extra completions beyond it -> counter holds 0xFFFF.
